seg_scan_decoder: RTL and testbench

Passive monitor sitting on the PipelineMips display outputs (an1/an2/seg1/seg2). It undoes the display path: samples the multiplexed seven-segment scan, recovers the eight displayed hex digits, and presents them as one 32-bit word per complete scan frame. Used in simulation benches and as an on-chip self-check of the register value selected by user_add.

---
 rtl/seg_scan_decoder.sv | 153 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Passive monitor for a two-group multiplexed seven-segment scan: recovers the
// eight displayed hex digits and presents them as one 32-bit word per complete frame.
module seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an1,
   input  logic [3:0]  an2,
   input  logic [7:0]  seg1,
   input  logic [7:0]  seg2,
   output logic        frame_valid,
   output logic [31:0] frame_value,
   output logic [7:0]  frame_dp,
   output logic [7:0]  frame_bad
);

   localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   // Index [1] is the upper group (an1/seg1), index [0] the lower group.
   logic [23:0]            sync1_q, sync2_q;
   logic [1:0][11:0]       samp;
   logic [1:0][11:0]       prev_q, prev_d;
   logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]             cap;
   logic [1:0][2:0]        cap_slot;
   logic [1:0][4:0]        cap_glyph;
   logic [1:0]             cap_dp;

   logic [31:0] shadow_nib_q, shadow_nib_d;
   logic [7:0]  shadow_dp_q, shadow_dp_d;
   logic [7:0]  shadow_bad_q, shadow_bad_d;
   logic [7:0]  mask_q, mask_d;
   logic        frame_valid_d;
   logic [31:0] frame_value_d;
   logic [7:0]  frame_dp_d, frame_bad_d;

   function automatic logic [1:0] an_idx(input logic [3:0] an);
      an_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (an[i]) an_idx = 2'(i);
      end
   endfunction

   // Returns {bad, nibble}; unknown glyphs decode to nibble 0 with bad set.
   function automatic logic [4:0] glyph_decode(input logic [6:0] s);
      case (s)
         7'h3F: glyph_decode = 5'h00;
         7'h06: glyph_decode = 5'h01;
         7'h5B: glyph_decode = 5'h02;
         7'h4F: glyph_decode = 5'h03;
         7'h66: glyph_decode = 5'h04;
         7'h6D: glyph_decode = 5'h05;
         7'h7D: glyph_decode = 5'h06;
         7'h07: glyph_decode = 5'h07;
         7'h7F: glyph_decode = 5'h08;
         7'h6F: glyph_decode = 5'h09;
         7'h77: glyph_decode = 5'h0A;
         7'h7C: glyph_decode = 5'h0B;
         7'h39: glyph_decode = 5'h0C;
         7'h5E: glyph_decode = 5'h0D;
         7'h79: glyph_decode = 5'h0E;
         7'h71: glyph_decode = 5'h0F;
         default: glyph_decode = 5'h10;
      endcase
   endfunction

   assign samp = sync2_q;

   // Per-group stability tracker; capture fires once when the count first hits STABLE.
   always_comb begin
      prev_d    = samp;
      cnt_d     = '0;
      cap       = '0;
      cap_slot  = '0;
      cap_glyph = '0;
      cap_dp    = '0;
      for (int g = 0; g < 2; g++) begin
         if ($onehot(samp[g][11:8])) begin
            if (samp[g] != prev_q[g]) begin
               cnt_d[g] = ONE;
            end else if (cnt_q[g] >= STABLE) begin
               cnt_d[g] = STABLE;
            end else begin
               cnt_d[g] = cnt_q[g] + ONE;
            end
            cap[g] = (cnt_d[g] == STABLE) &&
                     !((samp[g] == prev_q[g]) && (cnt_q[g] == STABLE));
         end
         cap_slot[g]  = {(g == 1), an_idx(samp[g][11:8])};
         cap_glyph[g] = glyph_decode(samp[g][6:0]);
         cap_dp[g]    = samp[g][7];
      end
   end

   // Frame assembler: copy out the cycle after the mask fills, captures still land.
   always_comb begin
      shadow_nib_d  = shadow_nib_q;
      shadow_dp_d   = shadow_dp_q;
      shadow_bad_d  = shadow_bad_q;
      mask_d        = (mask_q == 8'hFF) ? 8'h00 : mask_q;
      frame_valid_d = (mask_q == 8'hFF);
      frame_value_d = frame_value;
      frame_dp_d    = frame_dp;
      frame_bad_d   = frame_bad;
      if (frame_valid_d) begin
         frame_value_d = shadow_nib_q;
         frame_dp_d    = shadow_dp_q;
         frame_bad_d   = shadow_bad_q;
      end
      for (int g = 0; g < 2; g++) begin
         if (cap[g]) begin
            shadow_nib_d[cap_slot[g]*4 +: 4] = cap_glyph[g][3:0];
            shadow_bad_d[cap_slot[g]]        = cap_glyph[g][4];
            shadow_dp_d[cap_slot[g]]         = cap_dp[g];
            mask_d[cap_slot[g]]              = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         prev_q       <= '0;
         cnt_q        <= '0;
         shadow_nib_q <= '0;
         shadow_dp_q  <= '0;
         shadow_bad_q <= '0;
         mask_q       <= '0;
         frame_valid  <= 1'b0;
         frame_value  <= '0;
         frame_dp     <= '0;
         frame_bad    <= '0;
      end else begin
         sync1_q      <= {an1, seg1, an2, seg2};
         sync2_q      <= sync1_q;
         prev_q       <= prev_d;
         cnt_q        <= cnt_d;
         shadow_nib_q <= shadow_nib_d;
         shadow_dp_q  <= shadow_dp_d;
         shadow_bad_q <= shadow_bad_d;
         mask_q       <= mask_d;
         frame_valid  <= frame_valid_d;
         frame_value  <= frame_value_d;
         frame_dp     <= frame_dp_d;
         frame_bad    <= frame_bad_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives hand-built scans and checks the
// recovered frames against hand-computed words.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  an1, an2;
   logic [7:0]  seg1, seg2;
   logic        frame_valid;
   logic [31:0] frame_value;
   logic [7:0]  frame_dp, frame_bad;

   int n_cmp = 0;
   int n_bad = 0;
   int fv_cnt = 0;

   seg_scan_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .an1(an1), .an2(an2), .seg1(seg1), .seg2(seg2),
      .frame_valid(frame_valid), .frame_value(frame_value),
      .frame_dp(frame_dp), .frame_bad(frame_bad)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_valid === 1'b1) fv_cnt++;
   end

   function automatic logic [7:0] gl(input logic [3:0] d);
      case (d)
         4'h0: gl = 8'h3F;  4'h1: gl = 8'h06;  4'h2: gl = 8'h5B;  4'h3: gl = 8'h4F;
         4'h4: gl = 8'h66;  4'h5: gl = 8'h6D;  4'h6: gl = 8'h7D;  4'h7: gl = 8'h07;
         4'h8: gl = 8'h7F;  4'h9: gl = 8'h6F;  4'hA: gl = 8'h77;  4'hB: gl = 8'h7C;
         4'hC: gl = 8'h39;  4'hD: gl = 8'h5E;  4'hE: gl = 8'h79;  default: gl = 8'h71;
      endcase
   endfunction

   task automatic step(input logic [3:0] a1, input logic [7:0] s1,
                       input logic [3:0] a2, input logic [7:0] s2, input int hold);
      an1 = a1; seg1 = s1; an2 = a2; seg2 = s2;
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      step(4'h0, 8'h00, 4'h0, 8'h00, n);
   endtask

   task automatic scan(input logic [31:0] w);
      for (int i = 3; i >= 0; i--)
         step(4'(1 << i), gl(w[16+4*i +: 4]), 4'(1 << i), gl(w[4*i +: 4]), 8);
      idle(12);
   endtask

   task automatic test_reset;
      if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
      n_cmp++;
      if (frame_value !== 32'h0) begin n_bad++; $display("FAIL reset_value: got %h want 00000000", frame_value); end
      n_cmp++;
      if (frame_dp !== 8'h0) begin n_bad++; $display("FAIL reset_dp: got %h want 00", frame_dp); end
      n_cmp++;
      if (frame_bad !== 8'h0) begin n_bad++; $display("FAIL reset_bad: got %h want 00", frame_bad); end
      n_cmp++;
   endtask

   task automatic test_basic;
      int c0 = fv_cnt;
      scan(32'h1234ABCD);
      if (fv_cnt - c0 !== 1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", fv_cnt - c0); end
      n_cmp++;
      if (frame_value !== 32'h1234ABCD) begin n_bad++; $display("FAIL basic_value: got %h want 1234abcd", frame_value); end
      n_cmp++;
      if (frame_dp !== 8'h00) begin n_bad++; $display("FAIL basic_dp: got %h want 00", frame_dp); end
      n_cmp++;
      if (frame_bad !== 8'h00) begin n_bad++; $display("FAIL basic_bad: got %h want 00", frame_bad); end
      n_cmp++;
   endtask

   task automatic test_bad_dp;
      int c0 = fv_cnt;
      logic [31:0] w = 32'h1234ABCD;
      for (int i = 3; i >= 0; i--)
         step(4'(1 << i), (i == 2) ? 8'h00 : gl(w[16+4*i +: 4]),
              4'(1 << i), gl(w[4*i +: 4]) | ((i == 0) ? 8'h80 : 8'h00), 8);
      idle(12);
      if (fv_cnt - c0 !== 1) begin n_bad++; $display("FAIL baddp_count: got %0d want 1", fv_cnt - c0); end
      n_cmp++;
      if (frame_value !== 32'h1034ABCD) begin n_bad++; $display("FAIL baddp_value: got %h want 1034abcd", frame_value); end
      n_cmp++;
      if (frame_bad !== 8'h40) begin n_bad++; $display("FAIL baddp_bad: got %h want 40", frame_bad); end
      n_cmp++;
      if (frame_dp !== 8'h01) begin n_bad++; $display("FAIL baddp_dp: got %h want 01", frame_dp); end
      n_cmp++;
   endtask

   task automatic test_multi_anode;
      int c0 = fv_cnt;
      step(4'b0011, gl(4'h5), 4'b1000, gl(4'h9), 5);
      step(4'b0011, gl(4'h5), 4'b0100, gl(4'hA), 5);
      step(4'b0011, gl(4'h5), 4'b0010, gl(4'hB), 5);
      step(4'b0011, gl(4'h5), 4'b0001, gl(4'hC), 5);
      idle(12);
      if (fv_cnt - c0 !== 0) begin n_bad++; $display("FAIL multi_noframe: got %0d want 0", fv_cnt - c0); end
      n_cmp++;
      scan(32'h56789ABC);
      if (fv_cnt - c0 !== 1) begin n_bad++; $display("FAIL multi_count: got %0d want 1", fv_cnt - c0); end
      n_cmp++;
      if (frame_value !== 32'h56789ABC) begin n_bad++; $display("FAIL multi_value: got %h want 56789abc", frame_value); end
      n_cmp++;
   endtask

   task automatic test_glitch;
      int c0 = fv_cnt;
      step(4'b1000, gl(4'hE), 4'b1000, gl(4'hA), 3);
      step(4'b1000, gl(4'h1), 4'b1000, gl(4'hA), 8);
      step(4'b1000, gl(4'hE), 4'b1000, gl(4'hA), 3);
      step(4'b0100, gl(4'h2), 4'b0100, gl(4'hB), 8);
      step(4'b0010, gl(4'h3), 4'b0010, gl(4'hC), 8);
      step(4'b0001, gl(4'h4), 4'b0001, gl(4'hD), 8);
      idle(12);
      if (fv_cnt - c0 !== 1) begin n_bad++; $display("FAIL glitch_count: got %0d want 1", fv_cnt - c0); end
      n_cmp++;
      if (frame_value !== 32'h1234ABCD) begin n_bad++; $display("FAIL glitch_value: got %h want 1234abcd", frame_value); end
      n_cmp++;
   endtask

   task automatic test_rescan;
      int c0 = fv_cnt;
      step(4'b1000, gl(4'h1), 4'b1000, gl(4'hA), 8);
      step(4'b0100, gl(4'h2), 4'b0100, gl(4'hB), 8);
      step(4'b1000, gl(4'h9), 4'b0000, 8'h00, 4);
      step(4'b0010, gl(4'h3), 4'b0010, gl(4'hC), 8);
      step(4'b0001, gl(4'h4), 4'b0001, gl(4'hD), 8);
      idle(12);
      if (fv_cnt - c0 !== 1) begin n_bad++; $display("FAIL rescan_count: got %0d want 1", fv_cnt - c0); end
      n_cmp++;
      if (frame_value !== 32'h9234ABCD) begin n_bad++; $display("FAIL rescan_value: got %h want 9234abcd", frame_value); end
      n_cmp++;
   endtask

   task automatic test_reset_mid;
      int c0 = fv_cnt;
      step(4'b1000, gl(4'h7), 4'b1000, gl(4'h7), 8);
      step(4'b0100, gl(4'h7), 4'b0100, gl(4'h7), 8);
      step(4'b0010, gl(4'h7), 4'b0000, 8'h00, 8);
      idle(2);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b1;
      idle(4);
      c0 = fv_cnt;
      step(4'b0001, gl(4'hD), 4'b0010, gl(4'hE), 8);
      step(4'b0000, 8'h00, 4'b0001, gl(4'hF), 8);
      idle(12);
      if (fv_cnt - c0 !== 0) begin n_bad++; $display("FAIL rstmid_noframe: got %0d want 0", fv_cnt - c0); end
      n_cmp++;
      scan(32'hDEADBEEF);
      if (fv_cnt - c0 !== 1) begin n_bad++; $display("FAIL rstmid_count: got %0d want 1", fv_cnt - c0); end
      n_cmp++;
      if (frame_value !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rstmid_value: got %h want deadbeef", frame_value); end
      n_cmp++;
      if (frame_dp !== 8'h00 || frame_bad !== 8'h00) begin
         n_bad++; $display("FAIL rstmid_flags: got dp=%h bad=%h want 00/00", frame_dp, frame_bad);
      end
      n_cmp++;
   endtask

   initial begin
      rst = 1'b0;
      an1 = '0; an2 = '0; seg1 = '0; seg2 = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b1;
      idle(4);
      test_basic();
      test_bad_dp();
      test_multi_anode();
      test_glitch();
      test_rescan();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
